rcas_chunk_seq: RTL

- Sequential word-serial add/subtract engine.
- Processes a wide operand pair of W*N bits through one W-bit ripple add/sub slice, one chunk per clock, LSB chunk first.
- Chains the slice's carry-out into the next chunk's carry-in.
- Sits directly around the ripple-carry add/sub stage: it feeds operands and cin to the slice and consumes its sum and carry, so wide arithmetic costs no extra adder area.

---
 rtl/rcas_chunk_seq_pkg.sv | 19 +
 rtl/rcas_chunk_seq_if.sv | 27 ++
 rtl/rcas_chunk_seq_addsub_slice.sv | 31 +++
 rtl/rcas_chunk_seq.sv | 101 ++++++++++
 4 files changed

// File: rtl/rcas_chunk_seq_pkg.sv
// Shared types for the chunk-serial add/sub engine: FSM states, mode encoding, index width.
// Combinational helpers only; no latency, no backpressure.
package rcas_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b1;
   localparam logic MODE_SUB = 1'b0;

   // Chunk index needs at least one bit even when N would fit in zero.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rcas_chunk_seq_if.sv
// Operand/result bundle between a requester and the chunk-serial add/sub engine.
// No latency; start is ignored while busy, there is no other backpressure.
interface rcas_chunk_seq_if #(
   parameter int W = 8,
   parameter int N = 4
);
   logic             start;
   logic             mode;
   logic             cin;
   logic [W*N-1:0]   a;
   logic [W*N-1:0]   b;
   logic             busy;
   logic             done;
   logic [W*N-1:0]   result;
   logic             carry;
   logic             ovf;

   modport master (
      output start, mode, cin, a, b,
      input  busy, done, result, carry, ovf
   );

   modport slave (
      input  start, mode, cin, a, b,
      output busy, done, result, carry, ovf
   );
endinterface

// File: rtl/rcas_chunk_seq_addsub_slice.sv
// W-bit ripple-carry add/sub slice; y is inverted for subtract, caller supplies the +1 via ci.
// Purely combinational, zero latency, no backpressure.
module addsub_slice
   import rcas_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         mode,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   logic [W-1:0] y_eff;
   logic [W:0]   c;

   always_comb begin
      y_eff = (mode == MODE_ADD) ? y : ~y;
      c     = '0;
      s     = '0;
      c[0]  = ci;
      for (int i = 0; i < W; i++) begin
         s[i]   = x[i] ^ y_eff[i] ^ c[i];
         c[i+1] = (x[i] & y_eff[i]) | (c[i] & (x[i] ^ y_eff[i]));
      end
      co = c[W];
   end

endmodule

// File: rtl/rcas_chunk_seq.sv
// Wide add/sub computed one W-bit chunk per clock through a single slice, LSB first; done N+2 cycles after start.
// start is accepted only in IDLE; requests during RUN/DONE are dropped, nothing is queued.
module rcas_chunk_seq
   import rcas_pkg::*;
#(
   parameter int W = 8,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   rcas_chunk_seq_if.slave bus
);

   localparam int IW = idx_width(N);

   state_t           state;
   logic [IW-1:0]    idx;
   logic             c;
   logic             mode_q;
   logic [W*N-1:0]   a_q;
   logic [W*N-1:0]   b_q;
   logic [W*N-1:0]   result_q;
   logic             busy_q;
   logic             done_q;
   logic             carry_q;
   logic             ovf_q;

   logic [W-1:0]     s;
   logic             co;
   logic             b_msb_eff;

   addsub_slice #(.W(W)) u_slice (
      .x    (a_q[idx*W +: W]),
      .y    (b_q[idx*W +: W]),
      .mode (mode_q),
      .ci   (c),
      .s    (s),
      .co   (co)
   );

   assign b_msb_eff = (mode_q == MODE_ADD) ? b_q[W*N-1] : ~b_q[W*N-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         c        <= 1'b0;
         mode_q   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q    <= bus.a;
                  b_q    <= bus.b;
                  mode_q <= bus.mode;
                  // Subtract is a + ~b + 1, so the +1 rides in on the first carry.
                  c      <= (bus.mode == MODE_ADD) ? bus.cin : 1'b1;
                  idx    <= '0;
                  state  <= RUN;
                  busy_q <= 1'b1;
               end
            end
            RUN: begin
               result_q[idx*W +: W] <= s;
               c <= co;
               if (idx == IW'(N-1)) begin
                  state   <= DONE;
                  carry_q <= co;
                  ovf_q   <= (a_q[W*N-1] == b_msb_eff) && (s[W-1] != a_q[W*N-1]);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.carry  = carry_q;
   assign bus.ovf    = ovf_q;

endmodule
